pdm_decimator: RTL and testbench

//  Receive end of the 1-bit PDM audio link: turns a PDM bitstream back into unsigned PCM samples.

---
 rtl/pdm_decimator.sv | 122 ++++++++++++
 tb/tb_pdm_decimator.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/pdm_decimator.sv
// PDM-to-PCM receive path: 3rd-order CIC decimator (R = 2**LOG2_DECIM), output saturation,
// warm-up suppression. Define PDM_DEC_SYNC_EN to add a 2-flop input synchronizer.
module pdm_decimator #(
    parameter int unsigned N          = 12,
    parameter int unsigned LOG2_DECIM = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         pdm_in,
    input  logic         pdm_ce,
    output logic [N:0]   pcm_out,
    output logic         pcm_valid
);

    localparam int unsigned W   = 3 * LOG2_DECIM + 1;
    localparam int unsigned Msb = 3 * LOG2_DECIM;

    localparam logic [LOG2_DECIM-1:0] CntOne = LOG2_DECIM'(1);
    localparam logic [LOG2_DECIM-1:0] CntMax = '1;
    localparam logic [1:0]            WarmDone = 2'd2;

    logic bit_s;
    logic ce_s;

`ifdef PDM_DEC_SYNC_EN
    logic [1:0] bit_sync_q;
    logic [1:0] ce_sync_q;

    // Enable rides the same two flops as the data bit to keep them aligned.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_sync_q <= 2'b00;
            ce_sync_q  <= 2'b00;
        end else begin
            bit_sync_q <= {bit_sync_q[0], pdm_in};
            ce_sync_q  <= {ce_sync_q[0], pdm_ce};
        end
    end

    assign bit_s = bit_sync_q[1];
    assign ce_s  = ce_sync_q[1];
`else
    assign bit_s = pdm_in;
    assign ce_s  = pdm_ce;
`endif

    logic [W-1:0]          i1_q, i1_d;
    logic [W-1:0]          i2_q, i2_d;
    logic [W-1:0]          i3_q, i3_d;
    logic [W-1:0]          d1_q, d2_q, d3_q;
    logic [W-1:0]          c1, c2, c3;
    logic [LOG2_DECIM-1:0] cnt_q, cnt_d;
    logic                  dec_q, dec_d;
    logic [1:0]            warm_q;
    logic [N:0]            pcm_q, sample;
    logic                  valid_q;
    logic [W-1:0]          x;
    logic                  unused_c3;

    assign x = {{(W-1){1'b0}}, bit_s};

    always_comb begin
        i1_d  = i1_q + x;
        i2_d  = i2_q + i1_d;
        i3_d  = i3_q + i2_d;
        cnt_d = cnt_q + CntOne;
        dec_d = ce_s && (cnt_q == CntMax);
    end

    // Comb section works on the integrator state latched at the decimation edge, so the
    // integrators may keep absorbing bits on the same clock.
    always_comb begin
        c1 = i3_q - d1_q;
        c2 = c1 - d2_q;
        c3 = c2 - d3_q;
        if (c3[Msb]) begin
            sample = '1;
        end else begin
            sample = c3[Msb-1 -: N+1];
        end
    end

    assign unused_c3 = ^c3;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            i1_q    <= '0;
            i2_q    <= '0;
            i3_q    <= '0;
            d1_q    <= '0;
            d2_q    <= '0;
            d3_q    <= '0;
            cnt_q   <= '0;
            dec_q   <= 1'b0;
            warm_q  <= 2'd0;
            pcm_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            if (ce_s) begin
                i1_q  <= i1_d;
                i2_q  <= i2_d;
                i3_q  <= i3_d;
                cnt_q <= cnt_d;
            end
            dec_q   <= dec_d;
            valid_q <= dec_q && (warm_q == WarmDone);
            if (dec_q) begin
                d1_q  <= i3_q;
                d2_q  <= c1;
                d3_q  <= c2;
                pcm_q <= sample;
                if (warm_q != WarmDone) begin
                    warm_q <= warm_q + 2'd1;
                end
            end
        end
    end

    assign pcm_out   = pcm_q;
    assign pcm_valid = valid_q;

endmodule

// File: tb/tb_pdm_decimator.sv
// Directed bench for pdm_decimator: latency, strobe spacing, settled values for several
// bit patterns, enable gating, mid-period reset and a first-order modulator loopback.
module tb_pdm_decimator;

    localparam int N = 12;
`ifdef PDM_DEC_SYNC_EN
    localparam int SyncLat = 2;
`else
    localparam int SyncLat = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pdm_in = 1'b0;
    logic        pdm_ce = 1'b0;
    logic [N:0]  pcm_out;
    logic        pcm_valid;

    int          checks = 0;
    int          errors = 0;

    // Stimulus state: mode 0 zeros, 1 ones, 2 alternating 1,0, 3 pattern 1,0,0,0,
    // 4 first-order sigma-delta at 13'h0C00.
    int          mode = 0;
    int          ce_period = 1;
    int          ce_ph = 0;
    int          bit_idx = 0;
    bit          hold = 1'b0;
    logic [12:0] sd_acc = '0;

    always #5 clk = ~clk;

    pdm_decimator #(
        .N          (12),
        .LOG2_DECIM (5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pdm_in    (pdm_in),
        .pdm_ce    (pdm_ce),
        .pcm_out   (pcm_out),
        .pcm_valid (pcm_valid)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive inputs for the coming edge, take the edge, then settle past it.
    task automatic step();
        logic [13:0] s;
        pdm_ce = !hold && (ce_ph == 0);
        if (pdm_ce) begin
            case (mode)
                0: pdm_in = 1'b0;
                1: pdm_in = 1'b1;
                2: pdm_in = (bit_idx % 2 == 0);
                3: pdm_in = (bit_idx % 4 == 0);
                default: begin
                    s      = {1'b0, sd_acc} + 14'h0C00;
                    pdm_in = s[13];
                    sd_acc = s[12:0];
                end
            endcase
            bit_idx++;
        end
        ce_ph = (ce_ph + 1 == ce_period) ? 0 : ce_ph + 1;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int m, input int cp);
        mode      = m;
        ce_period = cp;
        hold      = 1'b0;
        rst_n     = 1'b0;
        repeat (3) step();
        ce_ph   = 0;
        bit_idx = 0;
        sd_acc  = '0;
        rst_n   = 1'b1;
    endtask

    // Returns the number of edges taken until pcm_valid is seen, or -1 on timeout.
    task automatic wait_valid(input int max, output int n);
        n = -1;
        for (int i = 1; i <= max; i++) begin
            step();
            if (pcm_valid) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        int n;
        int bad_val;
        int bad_gap;
        int seen;
        int diff;

        // 1: zeros, reset state, first-strobe latency, spacing, pulse width.
        // pcm_valid set by edge k is captured by a downstream flop at edge k+1.
        do_reset(0, 1);
        check("rst_pcm_out", 32'(pcm_out), 32'h0);
        check("rst_pcm_valid", 32'(pcm_valid), 32'h0);
        wait_valid(200, n);
        check("t1_first_latency", 32'(n + 1), 32'(98 + SyncLat));
        check("t1_pcm_out", 32'(pcm_out), 32'h0000);
        wait_valid(100, n);
        check("t1_spacing", 32'(n), 32'd32);
        step();
        check("t1_pulse_width", 32'(pcm_valid), 32'h0);

        // 2: ones saturate to full scale on every output, no wrap glitch.
        do_reset(1, 1);
        wait_valid(200, n);
        bad_val = 0;
        bad_gap = 0;
        for (int k = 0; k < 100; k++) begin
            wait_valid(100, n);
            if (n != 32) bad_gap++;
            if (pcm_out !== 13'h1FFF) bad_val++;
        end
        check("t2_bad_values", 32'(bad_val), 32'd0);
        check("t2_bad_spacing", 32'(bad_gap), 32'd0);
        check("t2_pcm_out", 32'(pcm_out), 32'h1FFF);

        // 3: alternating and 1-in-4 densities; enable held low freezes the output.
        do_reset(2, 1);
        repeat (4) wait_valid(200, n);
        check("t3_alt", 32'(pcm_out), 32'h1000);
        hold = 1'b1;
        seen = 0;
        repeat (100) begin
            step();
            if (pcm_valid) seen++;
        end
        check("t3_hold_no_valid", 32'(seen), 32'd0);
        check("t3_hold_pcm", 32'(pcm_out), 32'h1000);
        do_reset(3, 1);
        repeat (4) wait_valid(200, n);
        check("t3_quarter", 32'(pcm_out), 32'h0800);

        // 4: enable 1-in-3, same densities, strobe every 96 clks.
        do_reset(2, 3);
        repeat (3) wait_valid(400, n);
        wait_valid(200, n);
        check("t4_spacing", 32'(n), 32'd96);
        check("t4_alt", 32'(pcm_out), 32'h1000);
        do_reset(3, 3);
        repeat (3) wait_valid(400, n);
        wait_valid(200, n);
        check("t4_spacing_q", 32'(n), 32'd96);
        check("t4_quarter", 32'(pcm_out), 32'h0800);

        // 5: reset with the decimation counter at 17 (strobe observed at cnt=1, +16 bits).
        do_reset(2, 1);
        repeat (4) wait_valid(200, n);
        repeat (16) step();
        rst_n = 1'b0;
        step();
        rst_n   = 1'b1;
        bit_idx = 0;
        check("t5_rst_pcm_out", 32'(pcm_out), 32'h0);
        check("t5_rst_pcm_valid", 32'(pcm_valid), 32'h0);
        wait_valid(200, n);
        check("t5_first_latency", 32'(n + 1), 32'(98 + SyncLat));

        // 6: loopback from a first-order modulator at 13'h0C00.
        do_reset(4, 1);
        repeat (4) wait_valid(200, n);
        diff = int'(pcm_out) - 32'h0C00;
        if (diff < 0) diff = -diff;
        check("t6_loopback_within_8", 32'(diff <= 8), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
